param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram_pkg.sv | 14 +
 rtl/param_ram_if.sv | 32 +++
 rtl/ram_core.sv | 69 ++++++
 rtl/param_ram.sv | 102 ++++++++++
 tb/tb_param_ram.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/param_ram_pkg.sv
// Shared definitions for the param_ram slice.
//   RD_FIRST / WR_FIRST : read-during-write encodings for the RD_MODE parameter
//   state_e             : control FSM states (CLEAR while zeroing the array, READY otherwise)
package param_ram_pkg;

    localparam int unsigned RD_FIRST = 0;  // write access returns the pre-write word
    localparam int unsigned WR_FIRST = 1;  // write access returns the merged post-write word

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/param_ram_if.sv
// Access bus of param_ram.
//   ena    : access request
//   wea    : byte write enables, all-zero means read
//   addra  : word address
//   dina   : write data
//   douta  : registered read data
//   valida : one-cycle pulse, douta holds the result of the previous accepted access
//   busy   : clear sequence running, requests are dropped
interface param_ram_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) ();

    logic                  ena;
    logic [DATA_W/8-1:0]   wea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_W-1:0]     dina;
    logic [DATA_W-1:0]     douta;
    logic                  valida;
    logic                  busy;

    modport master (
        output ena, wea, addra, dina,
        input  douta, valida, busy
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta, valida, busy
    );

endinterface

// File: rtl/ram_core.sv
// Storage array with per-byte write and one registered read port.
//   clk_i   : clock
//   rst_i   : async active-high reset, clears only the read register
//   req_i   : load the read register this edge
//   we_i    : byte write enables (may be set with req_i low, e.g. for clearing)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, holds when req_i is low
module ram_core
    import param_ram_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RD_MODE = RD_FIRST
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NumBytes = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    assign old_word = mem_q[addr_i];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NumBytes; i++) begin
            if (we_i[i]) begin
                merged_word[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (req_i) begin
            rdata_d = (RD_MODE == WR_FIRST) ? merged_word : old_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_ram.sv
// Single-port byte-writable RAM with optional zeroing sequence after reset.
//   clka : clock
//   rsta : async active-high reset
//   bus  : param_ram_if slave (ena/wea/addra/dina in, douta/valida/busy out)
module param_ram
    import param_ram_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_MODE    = RD_FIRST,
    parameter int unsigned INIT_CLEAR = 1
) (
    input logic         clka,
    input logic         rsta,
    param_ram_if.slave  bus
);

    localparam state_e EntryState = (INIT_CLEAR != 0) ? CLEAR : READY;
    localparam logic   InitBusy   = (INIT_CLEAR != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic                accept;
    logic                clear_we;
    logic [DATA_W/8-1:0] core_we;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;

    assign accept   = bus.ena & ~busy_q;
    // Held off during reset so an aborted clear leaves the array untouched.
    assign clear_we = (state_q == CLEAR) & ~rsta;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = accept;
        unique case (state_q)
            CLEAR: begin
                busy_d = 1'b1;
                // Last address written this edge: leave without wrapping the counter.
                if (&cnt_q) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= EntryState;
            cnt_q   <= '0;
            busy_q  <= InitBusy;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        core_we    = '0;
        core_addr  = bus.addra;
        core_wdata = bus.dina;
        if (clear_we) begin
            core_we    = '1;
            core_addr  = cnt_q;
            core_wdata = '0;
        end else if (accept) begin
            core_we = bus.wea;
        end
    end

    ram_core #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RD_MODE (RD_MODE)
    ) u_ram_core (
        .clk_i   (clka),
        .rst_i   (rsta),
        .req_i   (accept),
        .we_i    (core_we),
        .addr_i  (core_addr),
        .wdata_i (core_wdata),
        .rdata_o (bus.douta)
    );

    assign bus.valida = valid_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: read-first and write-first 16x256 instances, a 32x16
// instance for full-rate throughput, and an INIT_CLEAR=0 instance for busy behaviour.
module tb_param_ram;

    logic clk;
    logic rst;

    int n_chk = 0;
    int n_err = 0;

    param_ram_if #(.DATA_W(16), .ADDR_W(8)) if0 ();
    param_ram_if #(.DATA_W(16), .ADDR_W(8)) if1 ();
    param_ram_if #(.DATA_W(32), .ADDR_W(4)) if2 ();
    param_ram_if #(.DATA_W(16), .ADDR_W(4)) if3 ();

    param_ram #(.DATA_W(16), .ADDR_W(8), .RD_MODE(0), .INIT_CLEAR(1)) u_dut0 (
        .clka (clk),
        .rsta (rst),
        .bus  (if0)
    );

    param_ram #(.DATA_W(16), .ADDR_W(8), .RD_MODE(1), .INIT_CLEAR(1)) u_dut1 (
        .clka (clk),
        .rsta (rst),
        .bus  (if1)
    );

    param_ram #(.DATA_W(32), .ADDR_W(4), .RD_MODE(0), .INIT_CLEAR(1)) u_dut2 (
        .clka (clk),
        .rsta (rst),
        .bus  (if2)
    );

    param_ram #(.DATA_W(16), .ADDR_W(4), .RD_MODE(0), .INIT_CLEAR(0)) u_dut3 (
        .clka (clk),
        .rsta (rst),
        .bus  (if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the same request on both 16-bit instances, then step to the next negedge.
    task automatic acc(input logic e, input logic [1:0] we, input logic [7:0] a,
                       input logic [15:0] d);
        if0.ena = e;  if0.wea = we;  if0.addra = a;  if0.dina = d;
        if1.ena = e;  if1.wea = we;  if1.addra = a;  if1.dina = d;
        @(negedge clk);
    endtask

    task automatic acc2(input logic e, input logic [3:0] we, input logic [3:0] a,
                        input logic [31:0] d);
        if2.ena = e;  if2.wea = we;  if2.addra = a;  if2.dina = d;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hF000_0000 ^ (32'h0101_0101 * 32'(i + 1));
    endfunction

    // Check both 16-bit instances after an access: valid flag and per-mode data.
    task automatic chk2(input string tag, input logic v, input logic [15:0] d0,
                        input logic [15:0] d1);
        check_eq({tag, " v0"}, 32'(if0.valida), 32'(v));
        check_eq({tag, " d0"}, 32'(if0.douta), 32'(d0));
        check_eq({tag, " v1"}, 32'(if1.valida), 32'(v));
        check_eq({tag, " d1"}, 32'(if1.douta), 32'(d1));
    endtask

    initial begin
        int n;
        int vseen;

        if0.ena = 0; if0.wea = 0; if0.addra = 0; if0.dina = 0;
        if1.ena = 0; if1.wea = 0; if1.addra = 0; if1.dina = 0;
        if2.ena = 0; if2.wea = 0; if2.addra = 0; if2.dina = 0;
        if3.ena = 0; if3.wea = 0; if3.addra = 0; if3.dina = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst busy0", 32'(if0.busy), 32'd1);
        check_eq("rst valid0", 32'(if0.valida), 32'd0);
        check_eq("rst dout0", 32'(if0.douta), 32'd0);
        check_eq("rst busy3", 32'(if3.busy), 32'd0);

        // First clear, aborted at cycle 100
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("busy at c100", 32'(if0.busy), 32'd1);
        check_eq("noclear busy3", 32'(if3.busy), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("midrst dout0", 32'(if0.douta), 32'd0);
            check_eq("midrst valid0", 32'(if0.valida), 32'd0);
            check_eq("midrst busy0", 32'(if0.busy), 32'd1);
        end

        // Restarted clear, with a request held on the bus the whole time
        rst = 1'b0;
        if0.ena = 1; if0.wea = 2'b11; if0.addra = 8'h05; if0.dina = 16'hFFFF;
        if1.ena = 1; if1.wea = 2'b11; if1.addra = 8'h05; if1.dina = 16'hFFFF;
        n = 0;
        vseen = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!if0.busy) break;
            n++;
            if (if0.valida || if1.valida) vseen++;
            @(negedge clk);
        end
        if0.ena = 0;
        if1.ena = 0;
        check_eq("clear cycles", 32'(n), 32'd256);
        check_eq("gated valid", 32'(vseen), 32'd0);
        check_eq("busy1 done", 32'(if1.busy), 32'd0);

        // Cleared contents
        acc(1, 2'b00, 8'h00, 16'h0); chk2("rd 00", 1, 16'h0000, 16'h0000);
        acc(1, 2'b00, 8'h7F, 16'h0); chk2("rd 7f", 1, 16'h0000, 16'h0000);
        acc(1, 2'b00, 8'hFF, 16'h0); chk2("rd ff", 1, 16'h0000, 16'h0000);
        acc(1, 2'b00, 8'h05, 16'h0); chk2("rd 05", 1, 16'h0000, 16'h0000);

        // Byte writes, back to back
        acc(1, 2'b11, 8'h10, 16'hABCD); chk2("wr10 full", 1, 16'h0000, 16'hABCD);
        acc(1, 2'b01, 8'h10, 16'h1234); chk2("wr10 lo", 1, 16'hABCD, 16'hAB34);
        acc(1, 2'b00, 8'h10, 16'h0);    chk2("rd 10", 1, 16'hAB34, 16'hAB34);
        acc(0, 2'b00, 8'h00, 16'h0);    chk2("idle hold", 0, 16'hAB34, 16'hAB34);

        // Read during write
        acc(1, 2'b11, 8'h20, 16'h5555); chk2("wr20 5555", 1, 16'h0000, 16'h5555);
        acc(1, 2'b11, 8'h20, 16'hAAAA); chk2("wr20 aaaa", 1, 16'h5555, 16'hAAAA);
        acc(0, 2'b11, 8'h20, 16'h1111); chk2("no ena", 0, 16'h5555, 16'hAAAA);
        acc(1, 2'b10, 8'h20, 16'h7788); chk2("wr20 hi", 1, 16'hAAAA, 16'h77AA);
        acc(1, 2'b00, 8'h20, 16'h0);    chk2("rd 20", 1, 16'h77AA, 16'h77AA);
        acc(0, 2'b00, 8'h00, 16'h0);

        // 32-bit instance: full-rate writes then reads
        for (int i = 0; i < 16; i++) begin
            acc2(1, 4'hF, 4'(i), pat(i));
            check_eq("w32 valid", 32'(if2.valida), 32'd1);
            check_eq("w32 old", if2.douta, 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            acc2(1, 4'h0, 4'(i), 32'h0);
            check_eq("r32 valid", 32'(if2.valida), 32'd1);
            check_eq("r32 data", if2.douta, pat(i));
        end
        acc2(1, 4'b0100, 4'd3, 32'h0077_0000);
        check_eq("w32 lane2 old", if2.douta, pat(3));
        acc2(1, 4'h0, 4'd3, 32'h0);
        check_eq("r32 lane2", if2.douta, (pat(3) & 32'hFF00_FFFF) | 32'h0077_0000);
        acc2(0, 4'h0, 4'd0, 32'h0);
        check_eq("r32 idle", 32'(if2.valida), 32'd0);

        // Full clear again wipes written words
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!if0.busy) break;
            n++;
            @(negedge clk);
        end
        check_eq("reclear cycles", 32'(n), 32'd256);
        acc(1, 2'b00, 8'h10, 16'h0); chk2("reclr 10", 1, 16'h0000, 16'h0000);
        acc(1, 2'b00, 8'h20, 16'h0); chk2("reclr 20", 1, 16'h0000, 16'h0000);
        acc(0, 2'b00, 8'h00, 16'h0);
        acc2(1, 4'h0, 4'd3, 32'h0);
        check_eq("reclr32", if2.douta, 32'h0);
        acc2(0, 4'h0, 4'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
